// File: rtl/uart_multi_lock_ctrl.sv
// uart_multi_lock_ctrl: UART-commanded controller for NUM_LOCKS independent locks.
// Commands are two bytes, <cmd><index>: cmd is CMD_OPEN or CMD_CLOSE, and index is
// an ASCII digit '0'..'NUM_LOCKS-1' or '*' for all locks. An inter-byte timeout
// abandons a half-received command. cmd_ack and cmd_err pulse for one cycle.
// Optional feature macro: UART_LOCK_AUTO_RELOCK_EN. When it is defined, each lock
// relocks on its own RELOCK_CYCLES after its most recent open.

// 8N1 receiver: two-flop synchronizer, start bit confirmed at mid-bit, and each
// data/stop bit sampled once per bit period. A frame with a bad stop bit is dropped.
module uart_multi_lock_rx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_pin,
    output logic       rx_valid,
    output logic [7:0] rx_byte
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT >= 2) ? (CLKS_PER_BIT / 2) - 1 : 0);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    rx_state_t     state_r;
    logic          sync1_r;
    logic          sync2_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;

    // Synchronize rx_pin, track the frame position and strobe out each good byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 1'b1;
            sync2_r   <= 1'b1;
            state_r   <= RX_IDLE;
            cnt_r     <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_valid  <= 1'b0;
            rx_byte   <= 8'h00;
        end else begin
            sync1_r  <= rx_pin;
            sync2_r  <= sync1_r;
            rx_valid <= 1'b0;
            case (state_r)
                RX_IDLE: begin
                    cnt_r     <= '0;
                    bit_idx_r <= 3'd0;
                    if (!sync2_r) begin
                        state_r <= RX_START;
                    end else begin
                        state_r <= RX_IDLE;
                    end
                end
                RX_START: begin
                    if (cnt_r == CNT_HALF) begin
                        cnt_r <= '0;
                        // A glitch that has gone high again by mid-bit is not a start bit.
                        state_r <= sync2_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        shift_r <= {sync2_r, shift_r[7:1]};
                        if (bit_idx_r == 3'd7) begin
                            state_r <= RX_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_r   <= '0;
                        state_r <= RX_IDLE;
                        if (sync2_r) begin
                            rx_valid <= 1'b1;
                            rx_byte  <= shift_r;
                        end else begin
                            rx_valid <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    state_r <= RX_IDLE;
                end
            endcase
        end
    end
endmodule

module uart_multi_lock_ctrl #(
    parameter int         CLKS_PER_BIT   = 434,
    parameter int         NUM_LOCKS      = 4,
    parameter logic [7:0] CMD_OPEN       = 8'h41,
    parameter logic [7:0] CMD_CLOSE      = 8'h43,
    parameter int         TIMEOUT_CYCLES = 5_000_000,
    parameter int         RELOCK_CYCLES  = 50_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_pin,
    output logic [NUM_LOCKS-1:0] lock_open,
    output logic                 cmd_ack,
    output logic                 cmd_err,
    output logic [7:0]           last_byte
);
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_STAR = 8'h2A;

    typedef enum logic {ST_IDLE, ST_WAIT_IDX} state_t;

    state_t               state_r;
    logic                 op_open_r;
    logic [TW-1:0]        tcnt_r;
    logic                 rx_valid_s;
    logic [7:0]           rx_byte_s;
    logic                 is_cmd_s;
    logic                 idx_ok_s;
    logic [7:0]           digit_s;
    logic [NUM_LOCKS-1:0] idx_mask_s;
    logic [NUM_LOCKS-1:0] apply_mask_s;
    logic [NUM_LOCKS-1:0] expire_s;
    logic [NUM_LOCKS-1:0] lock_next_s;

    uart_multi_lock_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk      (clk),
        .rst      (rst),
        .rx_pin   (rx_pin),
        .rx_valid (rx_valid_s),
        .rx_byte  (rx_byte_s)
    );

    // Classify the received byte as a command, a lock index, or neither.
    always_comb begin
        is_cmd_s   = (rx_byte_s == CMD_OPEN) || (rx_byte_s == CMD_CLOSE);
        digit_s    = rx_byte_s - ASCII_ZERO;
        idx_mask_s = '0;
        idx_ok_s   = 1'b0;
        if (rx_byte_s == ASCII_STAR) begin
            idx_mask_s = '1;
            idx_ok_s   = 1'b1;
        end else if ((rx_byte_s >= ASCII_ZERO) && (digit_s < 8'(NUM_LOCKS))) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                idx_mask_s[i] = (digit_s == 8'(i));
            end
            idx_ok_s = 1'b1;
        end else begin
            idx_mask_s = '0;
            idx_ok_s   = 1'b0;
        end
        if (rx_valid_s && (state_r == ST_WAIT_IDX) && idx_ok_s) begin
            apply_mask_s = idx_mask_s;
        end else begin
            apply_mask_s = '0;
        end
    end

    // Next lock state: expiry first, then the command so that a same-cycle open wins.
    always_comb begin
        lock_next_s = lock_open & ~expire_s;
        if (op_open_r) begin
            lock_next_s = lock_next_s | apply_mask_s;
        end else begin
            lock_next_s = lock_next_s & ~apply_mask_s;
        end
    end

`ifdef UART_LOCK_AUTO_RELOCK_EN
    localparam int RW = (RELOCK_CYCLES > 0) ? $clog2(RELOCK_CYCLES + 1) : 1;
    localparam logic [RW-1:0] RELOAD = RW'(RELOCK_CYCLES);

    logic [RW-1:0] relock_r [NUM_LOCKS];

    // Per-lock relock down-counters: open (re)loads, close clears, otherwise count to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                relock_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
                if (apply_mask_s[i]) begin
                    relock_r[i] <= op_open_r ? RELOAD : '0;
                end else if (relock_r[i] != '0) begin
                    relock_r[i] <= relock_r[i] - RW'(1);
                end else begin
                    relock_r[i] <= '0;
                end
            end
        end
    end

    // A counter sitting at 1 closes its lock on the next edge.
    always_comb begin
        for (int i = 0; i < NUM_LOCKS; i++) begin
            expire_s[i] = (relock_r[i] == RW'(1));
        end
    end
`else
    // Without auto-relock a lock only closes on command or reset.
    always_comb begin
        expire_s = '0;
    end
`endif

    // Command parser FSM with inter-byte timeout and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            op_open_r <= 1'b0;
            tcnt_r    <= '0;
            lock_open <= '0;
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            last_byte <= 8'h00;
        end else begin
            cmd_ack   <= 1'b0;
            cmd_err   <= 1'b0;
            lock_open <= lock_next_s;
            if (rx_valid_s) begin
                last_byte <= rx_byte_s;
            end else begin
                last_byte <= last_byte;
            end
            case (state_r)
                ST_IDLE: begin
                    tcnt_r <= '0;
                    if (rx_valid_s) begin
                        if (is_cmd_s) begin
                            op_open_r <= (rx_byte_s == CMD_OPEN);
                            state_r   <= ST_WAIT_IDX;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_WAIT_IDX: begin
                    // A byte on the timeout cycle takes priority over the timeout.
                    if (rx_valid_s) begin
                        if (is_cmd_s) begin
                            cmd_err   <= 1'b1;
                            op_open_r <= (rx_byte_s == CMD_OPEN);
                            tcnt_r    <= '0;
                        end else if (idx_ok_s) begin
                            cmd_ack <= 1'b1;
                            state_r <= ST_IDLE;
                        end else begin
                            cmd_err <= 1'b1;
                            state_r <= ST_IDLE;
                        end
                    end else if (tcnt_r == T_LAST) begin
                        cmd_err <= 1'b1;
                        state_r <= ST_IDLE;
                    end else begin
                        tcnt_r <= tcnt_r + TW'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
